// File: rtl/count_sequence_monitor.sv
// -----------------------------------------------------------------------------
// count_sequence_monitor
//
// Checks the output of a 2-bit mod-4 counter. count_in is sampled on edges
// where sample_en is high. The monitor locks after LOCK_LEN consecutive +1
// (mod 4) transitions. While locked it counts 3->0 wraps and flags any break
// in the sequence. After a break it drops back to SYNC and has to relock.
//
// Ports
//   clk         single clock; all logic on the rising edge
//   reset       synchronous, active-high; overrides every other input
//   count_in    counter value under observation (2 bits)
//   sample_en   count_in is sampled only on edges where this is 1
//   clr_err     synchronous clear of err_sticky and err_count
//   locked      1 while the FSM is in LOCKED
//   err_pulse   one-cycle pulse for each break detected in LOCKED
//   err_sticky  set by any counted error; held until clr_err or reset
//   wrap_count  3->0 transitions seen while LOCKED (wraps mod 2^WRAP_W)
//   err_count   counted errors, saturating at all-ones
//
// All outputs are registered. The effect of a sample is visible in the cycle
// after the edge that took the sample.
// -----------------------------------------------------------------------------
module count_sequence_monitor #(
    parameter int LOCK_LEN = 4,
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        count_in,
    input  logic              sample_en,
    input  logic              clr_err,
    output logic              locked,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [ERR_W-1:0]  err_count
);

    localparam int RUN_W = $clog2(LOCK_LEN + 1);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SYNC   = 2'b01;
    localparam logic [1:0] ST_LOCKED = 2'b10;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [1:0]        state_reg, state_next;
    logic [1:0]        prev_reg, prev_next;
    logic [RUN_W-1:0]  run_reg, run_next;
    logic              locked_reg;
    logic              err_pulse_reg;
    logic              err_sticky_reg, err_sticky_next;
    logic [WRAP_W-1:0] wrap_reg, wrap_next;
    logic [ERR_W-1:0]  err_cnt_reg, err_cnt_next;

    logic [1:0]        expected;
    logic              correct;
    logic [RUN_W-1:0]  run_inc;
    logic              lock_hit;
    logic              err_event;

    // The 2-bit add wraps 3 -> 0 by construction.
    assign expected = prev_reg + 2'd1;
    assign correct  = (count_in == expected);
    // run never exceeds LOCK_LEN-1, so run+1 still fits in RUN_W bits.
    assign run_inc  = run_reg + 1'b1;
    assign lock_hit = (run_inc == RUN_W'(LOCK_LEN));

    always_comb begin
        state_next = state_reg;
        prev_next  = prev_reg;
        run_next   = run_reg;
        wrap_next  = wrap_reg;
        err_event  = 1'b0;

        if (sample_en) begin
            prev_next = count_in;
        end

        case (state_reg)
            ST_IDLE: begin
                if (sample_en) begin
                    run_next   = '0;
                    state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (sample_en) begin
                    if (correct) begin
                        if (lock_hit) begin
                            // A wrap on this entering edge is deliberately
                            // not counted.
                            run_next   = '0;
                            state_next = ST_LOCKED;
                        end else begin
                            run_next = run_inc;
                        end
                    end else begin
                        run_next = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (sample_en) begin
                    if (correct) begin
                        if (prev_reg == 2'd3) begin
                            wrap_next = wrap_reg + 1'b1;
                        end
                    end else begin
                        err_event  = 1'b1;
                        run_next   = '0;
                        state_next = ST_SYNC;
                    end
                end
            end
            default: begin
                // Unreachable encoding: go back to IDLE and start over.
                run_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // If an error and clr_err arrive on the same edge, the error wins. The
    // count restarts at 1 and the sticky flag stays set.
    always_comb begin
        err_cnt_next    = err_cnt_reg;
        err_sticky_next = err_sticky_reg;
        if (err_event) begin
            err_sticky_next = 1'b1;
            if (clr_err) begin
                err_cnt_next = ERR_W'(1);
            end else if (err_cnt_reg != ERR_MAX) begin
                err_cnt_next = err_cnt_reg + 1'b1;
            end
        end else if (clr_err) begin
            err_cnt_next    = '0;
            err_sticky_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            prev_reg       <= 2'd0;
            run_reg        <= '0;
            locked_reg     <= 1'b0;
            err_pulse_reg  <= 1'b0;
            err_sticky_reg <= 1'b0;
            wrap_reg       <= '0;
            err_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            prev_reg       <= prev_next;
            run_reg        <= run_next;
            locked_reg     <= (state_next == ST_LOCKED);
            err_pulse_reg  <= err_event;
            err_sticky_reg <= err_sticky_next;
            wrap_reg       <= wrap_next;
            err_cnt_reg    <= err_cnt_next;
        end
    end

    assign locked     = locked_reg;
    assign err_pulse  = err_pulse_reg;
    assign err_sticky = err_sticky_reg;
    assign wrap_count = wrap_reg;
    assign err_count  = err_cnt_reg;

endmodule

// File: tb/tb_count_sequence_monitor.sv
// -----------------------------------------------------------------------------
// tb_count_sequence_monitor
//
// Directed testbench for count_sequence_monitor (LOCK_LEN=4, WRAP_W=8,
// ERR_W=2). Each tick drives one set of inputs, waits for a rising edge, and
// then checks the outputs 1 ns later against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_count_sequence_monitor;

    logic       clk;
    logic       reset;
    logic [1:0] count_in;
    logic       sample_en;
    logic       clr_err;
    logic       locked;
    logic       err_pulse;
    logic       err_sticky;
    logic [7:0] wrap_count;
    logic [1:0] err_count;

    int checks_total;
    int checks_failed;
    logic [1:0] last_val;   // most recent sampled value; used to build stimulus

    count_sequence_monitor #(
        .LOCK_LEN (4),
        .WRAP_W   (8),
        .ERR_W    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .sample_en  (sample_en),
        .clr_err    (clr_err),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .wrap_count (wrap_count),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks_total++;
        if (got !== exp) begin
            checks_failed++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Drive the inputs for one edge, then return 1 ns after that edge.
    task automatic tick(input logic en, input logic [1:0] v, input logic clr);
        sample_en = en;
        count_in  = v;
        clr_err   = clr;
        @(posedge clk);
        #1;
        if (en) last_val = v;
        sample_en = 1'b0;
        clr_err   = 1'b0;
    endtask

    task automatic samp(input logic [1:0] v);
        tick(1'b1, v, 1'b0);
    endtask

    // Break the sequence while locked (jump by +2), then relock with four
    // correct samples.
    task automatic break_relock(input logic clr, input int exp_err, input string tag);
        logic [1:0] v;
        v = last_val + 2'd2;
        tick(1'b1, v, clr);
        check({tag, "_pulse"}, int'(err_pulse), 1);
        check({tag, "_errcnt"}, int'(err_count), exp_err);
        check({tag, "_unlock"}, int'(locked), 0);
        for (int i = 0; i < 4; i++) begin
            v = last_val + 2'd1;
            samp(v);
        end
        check({tag, "_relock"}, int'(locked), 1);
    endtask

    task automatic check_all(input string tag, input int lk, input int pl,
                             input int st, input int wr, input int ec);
        check({tag, "_locked"}, int'(locked), lk);
        check({tag, "_pulse"}, int'(err_pulse), pl);
        check({tag, "_sticky"}, int'(err_sticky), st);
        check({tag, "_wrap"}, int'(wrap_count), wr);
        check({tag, "_errcnt"}, int'(err_count), ec);
    endtask

    initial begin
        checks_total  = 0;
        checks_failed = 0;
        last_val  = 2'd0;
        reset     = 1'b1;
        sample_en = 1'b0;
        count_in  = 2'd0;
        clr_err   = 1'b0;
        tick(1'b0, 2'd0, 1'b0);
        tick(1'b1, 2'd2, 1'b1);   // reset overrides the other inputs
        reset = 1'b0;
        check_all("reset", 0, 0, 0, 0, 0);

        // 1: lock after 0,1,2,3,0
        samp(2'd0); samp(2'd1); samp(2'd2); samp(2'd3);
        check("t1_not_yet", int'(locked), 0);
        samp(2'd0);
        check("t1_locked", int'(locked), 1);
        check("t1_wrap", int'(wrap_count), 0);

        // 2: a wrap while locked is counted; no errors
        samp(2'd1); check("t2_pulse1", int'(err_pulse), 0);
        samp(2'd2); check("t2_pulse2", int'(err_pulse), 0);
        samp(2'd3); check("t2_pulse3", int'(err_pulse), 0);
        samp(2'd0); check("t2_pulse0", int'(err_pulse), 0);
        check("t2_wrap", int'(wrap_count), 1);

        // 3: break (1 then 3), then relock with 0,1,2,3
        samp(2'd1);
        samp(2'd3);
        check_all("t3_break", 0, 1, 1, 1, 1);
        tick(1'b0, 2'd0, 1'b0);
        check("t3_pulse_gone", int'(err_pulse), 0);
        samp(2'd0); samp(2'd1); samp(2'd2);
        check("t3_sync", int'(locked), 0);
        samp(2'd3);
        check("t3_relock", int'(locked), 1);
        check("t3_wrap", int'(wrap_count), 1);

        // 4: sample_en low; every output holds
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 2'($urandom_range(0, 3)), 1'b0);
            check_all($sformatf("t4_hold%0d", i), 1, 0, 1, 1, 1);
        end

        // 5: clear with no error, then saturation at 3 with ERR_W=2
        tick(1'b0, 2'd0, 1'b1);
        check_all("t5_clr", 1, 0, 0, 1, 0);
        break_relock(1'b0, 1, "t5_b1");
        break_relock(1'b0, 2, "t5_b2");
        break_relock(1'b0, 3, "t5_b3");
        break_relock(1'b0, 3, "t5_b4");
        break_relock(1'b0, 3, "t5_b5");
        check("t5_sticky", int'(err_sticky), 1);
        check("t5_wrap", int'(wrap_count), 1);
        break_relock(1'b1, 1, "t5_clr_coinc");
        check("t5_coinc_sticky", int'(err_sticky), 1);

        // 6: drive wrap_count to 5, reset while locked, then relock
        for (int i = 0; i < 16; i++) samp(last_val + 2'd1);
        check_all("t6_pre", 1, 0, 1, 5, 1);
        reset = 1'b1;
        tick(1'b1, last_val + 2'd1, 1'b0);
        reset = 1'b0;
        check_all("t6_reset", 0, 0, 0, 0, 0);
        samp(2'd2); samp(2'd3); samp(2'd0); samp(2'd1);
        check("t6_sync", int'(locked), 0);
        samp(2'd2);
        check("t6_relock", int'(locked), 1);
        check("t6_wrap", int'(wrap_count), 0);

        $display("Result: errors=%0d of %0d checks", checks_failed, checks_total);
        $finish;
    end

endmodule
